// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing and two-stage pixel pipeline generator
module vga_timing_gen #(
    parameter int H_DISP      = 640,
    parameter int H_FP        = 16,
    parameter int H_PW        = 96,
    parameter int H_BP        = 48,
    parameter int V_DISP      = 480,
    parameter int V_FP        = 10,
    parameter int V_PW        = 2,
    parameter int V_BP        = 29,
    parameter int CLK_DIV     = 4,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_H_BITS = 8,
    parameter int ADDR_V_BITS = 7,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0
) (
    input  logic                               CLK,
    input  logic                               Reset,
    input  logic [1:0]                         MODE,
    input  logic [15:0]                        CONFIG_COLOURS,
    output logic [ADDR_V_BITS+ADDR_H_BITS-1:0] VGA_ADDR,
    input  logic [7:0]                         VGA_DATA,
    output logic                               PIX_EN,
    output logic                               VGA_HS,
    output logic                               VGA_VS,
    output logic                               VGA_DE,
    output logic [7:0]                         VGA_COLOUR,
    output logic                               FRAME_START,
    output logic                               LINE_START
);

    localparam int H_TOTAL = H_DISP + H_FP + H_PW + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_PW + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);

    // Bars are H_DISP/8 wide; a width of at least one keeps tiny displays sane.
    localparam int BAR_W   = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;
    localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]  H_DISP_C   = HW'(H_DISP);
    localparam logic [VW-1:0]  V_DISP_C   = VW'(V_DISP);
    localparam logic [HW-1:0]  H_EDGE     = HW'(H_DISP - 1);
    localparam logic [VW-1:0]  V_EDGE     = VW'(V_DISP - 1);
    localparam logic [HW-1:0]  HS_FIRST   = HW'(H_DISP + H_FP);
    localparam logic [HW-1:0]  HS_LAST    = HW'(H_DISP + H_FP + H_PW - 1);
    localparam logic [VW-1:0]  VS_FIRST   = VW'(V_DISP + V_FP);
    localparam logic [VW-1:0]  VS_LAST    = VW'(V_DISP + V_FP + V_PW - 1);
    localparam logic [BCW-1:0] BAR_LAST   = BCW'(BAR_W - 1);

    typedef enum logic [1:0] {
        MODE_FB        = 2'd0,
        MODE_SOLID     = 2'd1,
        MODE_BARS      = 2'd2,
        MODE_FB_BORDER = 2'd3
    } mode_t;

    logic [DW-1:0]  div;
    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;
    mode_t          mode_q;

    logic           h_last;
    logic           v_last;
    logic           visible;
    logic           hs_act;
    logic           vs_act;
    logic           border;
    logic [HW-1:0]  h_scaled;
    logic [VW-1:0]  v_scaled;

    logic           s1_hs;
    logic           s1_vs;
    logic           s1_de;
    logic           s1_border;
    logic [2:0]     s1_bar;
    logic [7:0]     pix_colour;

    function automatic logic [7:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 8'hFF;
            3'd1:    bar_colour = 8'hFC;
            3'd2:    bar_colour = 8'h1F;
            3'd3:    bar_colour = 8'h1C;
            3'd4:    bar_colour = 8'hE3;
            3'd5:    bar_colour = 8'hE0;
            3'd6:    bar_colour = 8'h03;
            default: bar_colour = 8'h00;
        endcase
    endfunction

    // Pixel-rate divider; the enable is a pure decode so it is low while div is held in reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign PIX_EN = (div == DIV_LAST);

    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);

    // Raster counters, display-first so (0,0) is the top-left visible pixel.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            h <= '0;
            v <= '0;
        end else if (PIX_EN) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    // Bar index tracks h/BAR_W by counting within each bar, saturating at the last bar.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (PIX_EN) begin
            if (h_last) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + BCW'(1);
            end
        end
    end

    // Display mode is only latched at the frame wrap so a frame never mixes modes.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mode_q <= MODE_FB;
        end else if (PIX_EN && h_last && v_last) begin
            mode_q <= mode_t'(MODE);
        end
    end

    // Strobes mark the cycle right after the tick that moves the raster to a new line/frame.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            LINE_START  <= PIX_EN && h_last;
            FRAME_START <= PIX_EN && h_last && v_last;
        end
    end

    // Region decodes for the current counter position.
    always_comb begin
        visible  = (h < H_DISP_C) && (v < V_DISP_C);
        hs_act   = (h >= HS_FIRST) && (h <= HS_LAST);
        vs_act   = (v >= VS_FIRST) && (v <= VS_LAST);
        border   = visible && ((h == '0) || (h == H_EDGE) || (v == '0) || (v == V_EDGE));
        h_scaled = h >> SCALE_SHIFT;
        v_scaled = v >> SCALE_SHIFT;
    end

    // Stage 1: issue the frame-buffer address and carry the per-pixel flags alongside it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            VGA_ADDR  <= '0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_de     <= 1'b0;
            s1_border <= 1'b0;
            s1_bar    <= '0;
        end else if (PIX_EN) begin
            VGA_ADDR  <= visible ? {ADDR_V_BITS'(v_scaled), ADDR_H_BITS'(h_scaled)} : '0;
            s1_hs     <= hs_act;
            s1_vs     <= vs_act;
            s1_de     <= visible;
            s1_border <= border;
            s1_bar    <= bar_idx;
        end
    end

    // Colour source selection for the pixel whose RAM data is now on VGA_DATA.
    always_comb begin
        pix_colour = VGA_DATA;
        case (mode_q)
            MODE_FB:        pix_colour = VGA_DATA;
            MODE_SOLID:     pix_colour = CONFIG_COLOURS[7:0];
            MODE_BARS:      pix_colour = bar_colour(s1_bar);
            MODE_FB_BORDER: pix_colour = s1_border ? CONFIG_COLOURS[15:8] : VGA_DATA;
            default:        pix_colour = VGA_DATA;
        endcase
    end

    // Stage 2: drive the connector pins, blanking colour outside the visible region.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            VGA_HS     <= ~HS_POL;
            VGA_VS     <= ~VS_POL;
            VGA_DE     <= 1'b0;
            VGA_COLOUR <= '0;
        end else if (PIX_EN) begin
            VGA_HS     <= s1_hs ? HS_POL : ~HS_POL;
            VGA_VS     <= s1_vs ? VS_POL : ~VS_POL;
            VGA_DE     <= s1_de;
            VGA_COLOUR <= s1_de ? pix_colour : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen at default and small parameters
module tb_vga_timing_gen;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [1:0]  mode;
    logic [15:0] cfg;

    logic [14:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_pix_en, a_hs, a_vs, a_de, a_fs, a_ls;
    logic        b_pix_en, b_hs, b_vs, b_de, b_fs, b_ls;
    logic [7:0]  a_colour, b_colour;

    vga_timing_gen dut_a (
        .CLK(clk), .Reset(rst_a), .MODE(mode), .CONFIG_COLOURS(cfg),
        .VGA_ADDR(a_addr), .VGA_DATA(a_data), .PIX_EN(a_pix_en),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_DE(a_de), .VGA_COLOUR(a_colour),
        .FRAME_START(a_fs), .LINE_START(a_ls)
    );

    vga_timing_gen #(
        .H_DISP(8), .H_FP(1), .H_PW(2), .H_BP(1),
        .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
        .CLK_DIV(2), .HS_POL(1'b1)
    ) dut_b (
        .CLK(clk), .Reset(rst_b), .MODE(mode), .CONFIG_COLOURS(cfg),
        .VGA_ADDR(b_addr), .VGA_DATA(b_data), .PIX_EN(b_pix_en),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_DE(b_de), .VGA_COLOUR(b_colour),
        .FRAME_START(b_fs), .LINE_START(b_ls)
    );

    // Frame-buffer RAM models: data is the low address byte, one clock later.
    always @(posedge clk) begin
        a_data <= a_addr[7:0];
        b_data <= b_addr[7:0];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Which DUT the scoreboard is looking at, and its timing parameters.
    bit sel;
    int p_div, p_hd, p_hfp, p_hpw, p_hbp, p_vd, p_vfp, p_vpw, p_vbp, p_shift;
    bit p_hpol, p_vpol;

    logic [31:0] o_addr, o_pix_en, o_hs, o_vs, o_de, o_colour, o_fs, o_ls;
    assign o_addr   = sel ? 32'(b_addr)   : 32'(a_addr);
    assign o_pix_en = sel ? 32'(b_pix_en) : 32'(a_pix_en);
    assign o_hs     = sel ? 32'(b_hs)     : 32'(a_hs);
    assign o_vs     = sel ? 32'(b_vs)     : 32'(a_vs);
    assign o_de     = sel ? 32'(b_de)     : 32'(a_de);
    assign o_colour = sel ? 32'(b_colour) : 32'(a_colour);
    assign o_fs     = sel ? 32'(b_fs)     : 32'(a_fs);
    assign o_ls     = sel ? 32'(b_ls)     : 32'(a_ls);

    typedef struct {
        int addr;
        int hs;
        int vs;
        int de;
        int colour;
        int lit;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mh, mv, mmode;
    int   cyc, last_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int bar_col(input int idx);
        case (idx)
            0: return 'hFF;
            1: return 'hFC;
            2: return 'h1F;
            3: return 'h1C;
            4: return 'hE3;
            5: return 'hE0;
            6: return 'h03;
            default: return 'h00;
        endcase
    endfunction

    function automatic exp_t model_pixel(input int h, input int v, input int md, input logic [15:0] cf);
        exp_t e;
        bit   vis;
        int   idx;
        logic [6:0] av;
        logic [7:0] ah;
        vis = (h < p_hd) && (v < p_vd);
        av  = 7'(v >> p_shift);
        ah  = 8'(h >> p_shift);
        e.addr = vis ? int'({av, ah}) : 0;
        e.hs = ((h >= p_hd + p_hfp) && (h < p_hd + p_hfp + p_hpw)) ? int'(p_hpol) : int'(!p_hpol);
        e.vs = ((v >= p_vd + p_vfp) && (v < p_vd + p_vfp + p_vpw)) ? int'(p_vpol) : int'(!p_vpol);
        e.de = vis ? 1 : 0;
        e.lit = (!sel && h == 5 && v == 9) ? 1 : 0;
        e.colour = 0;
        if (vis) begin
            case (md)
                0: e.colour = e.addr & 'hFF;
                1: e.colour = int'(cf[7:0]);
                2: begin
                    idx = h / (p_hd / 8);
                    if (idx > 7) idx = 7;
                    e.colour = bar_col(idx);
                end
                default: e.colour = (h == 0 || h == p_hd - 1 || v == 0 || v == p_vd - 1)
                                    ? int'(cf[15:8]) : (e.addr & 'hFF);
            endcase
        end
        return e;
    endfunction

    task automatic model_init();
        mh = 0;
        mv = 0;
        mmode = 0;
        last_fs = -1;
        q.delete();
    endtask

    task automatic chk_reset();
        chk("rst_addr", o_addr, 0);
        chk("rst_de", o_de, 0);
        chk("rst_colour", o_colour, 0);
        chk("rst_pix_en", o_pix_en, 0);
        chk("rst_hs", o_hs, 32'(!p_hpol));
        chk("rst_vs", o_vs, 32'(!p_vpol));
        chk("rst_frame_start", o_fs, 0);
        chk("rst_line_start", o_ls, 0);
    endtask

    // Runs n pixel ticks starting at a negedge where the divider is at 0.
    task automatic run_ticks(input int n);
        exp_t e;
        int   ht, vt;
        bit   wrap_h, wrap_f;
        ht = p_hd + p_hfp + p_hpw + p_hbp;
        vt = p_vd + p_vfp + p_vpw + p_vbp;
        for (int k = 0; k < n; k++) begin
            wrap_h = (mh == ht - 1);
            wrap_f = wrap_h && (mv == vt - 1);
            for (int c = 1; c <= p_div; c++) begin
                @(negedge clk);
                cyc++;
                chk("pix_en", o_pix_en, (c == p_div - 1) ? 1 : 0);
                chk("line_start", o_ls, (c == p_div && wrap_h) ? 1 : 0);
                chk("frame_start", o_fs, (c == p_div && wrap_f) ? 1 : 0);
                if (o_fs === 32'd1) begin
                    if (last_fs >= 0) chk("frame_spacing", 32'(cyc - last_fs), 32'(ht * vt * p_div));
                    last_fs = cyc;
                end
            end
            q.push_back(model_pixel(mh, mv, mmode, cfg));
            chk("addr", o_addr, q[$].addr);
            if (q[$].lit != 0) chk("addr_pix_5_9", o_addr, 32'h0201);
            if (q.size() > 1) begin
                e = q.pop_front();
                chk("hs", o_hs, e.hs);
                chk("vs", o_vs, e.vs);
                chk("de", o_de, e.de);
                chk("colour", o_colour, e.colour);
                if (e.lit != 0) chk("colour_pix_5_9", o_colour, 32'h01);
            end
            if (wrap_h) begin
                mh = 0;
                if (wrap_f) begin
                    mv = 0;
                    mmode = int'(mode);
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        mode  = 2'd0;
        cfg   = 16'h0000;
        cyc   = 0;

        // Default 640x480 timing.
        sel = 1'b0;
        p_div = 4; p_hd = 640; p_hfp = 16; p_hpw = 96; p_hbp = 48;
        p_vd = 480; p_vfp = 10; p_vpw = 2; p_vbp = 29; p_shift = 2;
        p_hpol = 1'b0; p_vpol = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst_a = 1'b0;
        model_init();
        run_ticks(800 * 10 + 10);
        run_ticks(290);

        // Asynchronous reset mid-line at h=300.
        #1 rst_a = 1'b1;
        #1 chk_reset();
        repeat (2) @(negedge clk);
        chk_reset();
        rst_a = 1'b0;
        model_init();
        run_ticks(805);

        // Small timing, active-high HS, mode walk across frames.
        sel = 1'b1;
        p_div = 2; p_hd = 8; p_hfp = 1; p_hpw = 2; p_hbp = 1;
        p_vd = 4; p_vfp = 1; p_vpw = 1; p_vbp = 1; p_shift = 2;
        p_hpol = 1'b1; p_vpol = 1'b0;
        @(negedge clk);
        chk_reset();
        rst_b = 1'b0;
        model_init();
        run_ticks(40);
        mode = 2'd1;
        cfg  = 16'h00A5;
        run_ticks(84);
        mode = 2'd2;
        run_ticks(84);
        mode = 2'd3;
        cfg  = 16'h4C00;
        run_ticks(84);
        run_ticks(84);

        #1 rst_b = 1'b1;
        #1 chk_reset();
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        model_init();
        run_ticks(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
